snd_cmd_mailbox: RTL and testbench

Parametrised command mailbox between the main CPU and the Z80 sound CPU.
- Carries NUM_CH host-to-sound command channels, each a FIFO, plus one sound-to-host reply latch.
- Generates the Z80 INT_n and NMI_n levels and the IM0 RST vector byte.
- Generalises the fixed two-latch, single-entry sound latch to configurable channel count and depth, with reply and overflow reporting.

---
 rtl/snd_cmd_mailbox_if.sv | 38 +++
 rtl/snd_cmd_mailbox.sv | 150 +++++++++++++++
 tb/tb_snd_cmd_mailbox.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/snd_cmd_mailbox_if.sv
// Host/Z80 side signal bundle for snd_cmd_mailbox; master drives strobes and data,
// slave is the mailbox itself.
interface snd_cmd_mailbox_if #(
  parameter int NUM_CH = 2
);
  logic              host_wr;
  logic [1:0]        host_ch;
  logic [7:0]        host_din;
  logic [NUM_CH-1:0] host_full;
  logic              snd_rd;
  logic [1:0]        snd_ch;
  logic [7:0]        snd_dout;
  logic [NUM_CH-1:0] snd_pending;
  logic              ext_irq_n;
  logic              int_n;
  logic              nmi_n;
  logic [7:0]        irq_vec;
  logic              snd_reply_wr;
  logic [7:0]        snd_reply_din;
  logic [7:0]        host_reply;
  logic              host_reply_valid;
  logic              host_reply_rd;
  logic [NUM_CH-1:0] ovf;

  modport master (
    output host_wr, host_ch, host_din, snd_rd, snd_ch, ext_irq_n,
           snd_reply_wr, snd_reply_din, host_reply_rd,
    input  host_full, snd_dout, snd_pending, int_n, nmi_n, irq_vec,
           host_reply, host_reply_valid, ovf
  );

  modport slave (
    input  host_wr, host_ch, host_din, snd_rd, snd_ch, ext_irq_n,
           snd_reply_wr, snd_reply_din, host_reply_rd,
    output host_full, snd_dout, snd_pending, int_n, nmi_n, irq_vec,
           host_reply, host_reply_valid, ovf
  );
endinterface

// File: rtl/snd_cmd_mailbox.sv
// Main-CPU to Z80 command mailbox: NUM_CH FIFO channels, reply latch, INT/NMI/IM0 vector.
// Define SND_MAILBOX_OVF_EN to get sticky per-channel overflow flags on the ovf port.
module snd_cmd_mailbox #(
  parameter int NUM_CH     = 2,
  parameter int DEPTH_LOG2 = 2,
  parameter int NMI_CH     = 1
) (
  input  logic               CLK_32M,
  input  logic               RESET_N,
  snd_cmd_mailbox_if.slave   bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;

  logic [NUM_CH-1:0]     wr_sel, rd_sel, push_ok, pop_ok;
  logic [NUM_CH-1:0]     pend, pend_d, full, irq_src, irq_src_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_all [4];
  logic [DEPTH_LOG2-1:0] rd_ptr_all [4];
  logic [DEPTH_LOG2+1:0] wr_addr, rd_addr;
  logic [7:0]            mem_q [4*DEPTH];
  logic [7:0]            snd_dout_q;
  logic                  irq_pend_q, nmi_n_q, nmi_pend_d;
  logic [7:0]            reply_q;
  logic                  reply_valid_q;
  logic                  any_irq;
  logic [1:0]            low_irq;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_ch
      if (gi < NUM_CH) begin : g_on
        logic [PW-1:0] cnt_q, cnt_d, wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;

        assign wr_sel[gi]  = bus.host_wr && (bus.host_ch == 2'(gi));
        assign rd_sel[gi]  = bus.snd_rd && (bus.snd_ch == 2'(gi));
        assign full[gi]    = (cnt_q == PW'(DEPTH));
        assign pend[gi]    = (cnt_q != '0);
        assign pop_ok[gi]  = rd_sel[gi] && pend[gi];
        // A same-cycle pop frees the slot, so a push to a full channel still lands.
        assign push_ok[gi] = wr_sel[gi] && (!full[gi] || pop_ok[gi]);

        always_comb begin
          cnt_d    = cnt_q;
          wr_ptr_d = wr_ptr_q;
          rd_ptr_d = rd_ptr_q;
          if (push_ok[gi] && !pop_ok[gi]) cnt_d = cnt_q + PW'(1);
          if (!push_ok[gi] && pop_ok[gi]) cnt_d = cnt_q - PW'(1);
          if (push_ok[gi]) wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
          if (pop_ok[gi])  rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        end
        assign pend_d[gi] = (cnt_d != '0);

        always_ff @(posedge CLK_32M or negedge RESET_N) begin
          if (!RESET_N) begin
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
          end else begin
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
          end
        end
        assign wr_ptr_all[gi] = wr_ptr_q[DEPTH_LOG2-1:0];
        assign rd_ptr_all[gi] = rd_ptr_q[DEPTH_LOG2-1:0];

        if (gi != NMI_CH) begin : g_irq
          assign irq_src[gi]   = pend[gi];
          assign irq_src_d[gi] = pend_d[gi];
        end else begin : g_nmi
          assign irq_src[gi]   = 1'b0;
          assign irq_src_d[gi] = 1'b0;
        end

`ifdef SND_MAILBOX_OVF_EN
        logic ovf_q;
        always_ff @(posedge CLK_32M or negedge RESET_N) begin
          if (!RESET_N)                     ovf_q <= 1'b0;
          else if (wr_sel[gi] && !push_ok[gi]) ovf_q <= 1'b1;
          else if (pop_ok[gi])              ovf_q <= 1'b0;
        end
        assign bus.ovf[gi] = ovf_q;
`endif
      end else begin : g_off
        assign wr_ptr_all[gi] = '0;
        assign rd_ptr_all[gi] = '0;
      end
    end

    if (NMI_CH < NUM_CH) begin : g_nmi_src
      assign nmi_pend_d = pend_d[NMI_CH];
    end else begin : g_no_nmi
      assign nmi_pend_d = 1'b0;
    end
  endgenerate

`ifndef SND_MAILBOX_OVF_EN
  assign bus.ovf = '0;
`endif

  assign wr_addr = {bus.host_ch, wr_ptr_all[bus.host_ch]};
  assign rd_addr = {bus.snd_ch, rd_ptr_all[bus.snd_ch]};

  always_ff @(posedge CLK_32M) begin
    if (|push_ok) mem_q[wr_addr] <= bus.host_din;
  end

  always_ff @(posedge CLK_32M or negedge RESET_N) begin
    if (!RESET_N) begin
      snd_dout_q    <= 8'hFF;
      irq_pend_q    <= 1'b0;
      nmi_n_q       <= 1'b1;
      reply_q       <= 8'h00;
      reply_valid_q <= 1'b0;
    end else begin
      if (bus.snd_rd) snd_dout_q <= (|pop_ok) ? mem_q[rd_addr] : 8'hFF;
      irq_pend_q <= |irq_src_d;
      nmi_n_q    <= ~nmi_pend_d;
      if (bus.snd_reply_wr) begin
        reply_q       <= bus.snd_reply_din;
        reply_valid_q <= 1'b1;
      end else if (bus.host_reply_rd) begin
        reply_valid_q <= 1'b0;
      end
    end
  end

  // Pending state is registered; the YM2151 line is merged live so reset leaves int_n = ext_irq_n.
  assign bus.int_n = bus.ext_irq_n & ~irq_pend_q;

  always_comb begin
    any_irq = 1'b0;
    low_irq = 2'b00;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (irq_src[i]) begin
        any_irq = 1'b1;
        low_irq = 2'(i);
      end
    end
  end

  assign bus.irq_vec          = {2'b11, ~any_irq, bus.ext_irq_n,
                                 (any_irq ? ~low_irq : 2'b11), 2'b11};
  assign bus.nmi_n            = nmi_n_q;
  assign bus.snd_dout         = snd_dout_q;
  assign bus.snd_pending      = pend;
  assign bus.host_full        = full;
  assign bus.host_reply       = reply_q;
  assign bus.host_reply_valid = reply_valid_q;
endmodule

// File: tb/tb_snd_cmd_mailbox.sv
// Self-checking bench for snd_cmd_mailbox: directed scenarios plus random traffic
// compared against a queue-based model of the mailbox.
module tb_snd_cmd_mailbox;
  localparam int NUM_CH = 2;
  localparam int DEPTH_LOG2 = 2;
  localparam int NMI_CH = 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;
`ifdef SND_MAILBOX_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  snd_cmd_mailbox_if #(.NUM_CH(NUM_CH)) bus ();

  snd_cmd_mailbox #(.NUM_CH(NUM_CH), .DEPTH_LOG2(DEPTH_LOG2), .NMI_CH(NMI_CH)) dut (
    .CLK_32M (clk),
    .RESET_N (rst_n),
    .bus     (bus.slave)
  );

  int n_checks = 0;
  int n_fail = 0;

  // Reference model
  logic [7:0] mq [4][$];
  logic [7:0] m_dout = 8'hFF;
  logic [7:0] m_reply = 8'h00;
  logic       m_valid = 1'b0;
  logic [NUM_CH-1:0] m_ovf = '0;

  function automatic logic [NUM_CH-1:0] m_pend();
    logic [NUM_CH-1:0] p;
    for (int i = 0; i < NUM_CH; i++) p[i] = (mq[i].size() != 0);
    return p;
  endfunction

  function automatic logic [NUM_CH-1:0] m_full();
    logic [NUM_CH-1:0] f;
    for (int i = 0; i < NUM_CH; i++) f[i] = (mq[i].size() == DEPTH);
    return f;
  endfunction

  function automatic bit m_irq_any();
    for (int i = 0; i < NUM_CH; i++) if (i != NMI_CH && mq[i].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [7:0] m_vec(input logic ext);
    int low;
    low = -1;
    for (int i = NUM_CH - 1; i >= 0; i--) if (i != NMI_CH && mq[i].size() != 0) low = i;
    if (low < 0) return {2'b11, 1'b1, ext, 2'b11, 2'b11};
    return {2'b11, 1'b0, ext, 2'(3 - low), 2'b11};
  endfunction

  function automatic logic m_nmi_n();
    if (NMI_CH >= NUM_CH) return 1'b1;
    return (mq[NMI_CH].size() == 0);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mq[i].delete();
    m_dout = 8'hFF; m_reply = 8'h00; m_valid = 1'b0; m_ovf = '0;
  endtask

  task automatic cycle(input logic wr, input logic [1:0] wch, input logic [7:0] din,
                       input logic rd, input logic [1:0] rch,
                       input logic rwr, input logic [7:0] rdin, input logic rrd);
    bit pop_ok, push_ok;
    bus.host_wr = wr; bus.host_ch = wch; bus.host_din = din;
    bus.snd_rd = rd; bus.snd_ch = rch;
    bus.snd_reply_wr = rwr; bus.snd_reply_din = rdin; bus.host_reply_rd = rrd;
    pop_ok  = rd && (rch < NUM_CH) && (mq[rch].size() != 0);
    push_ok = wr && (wch < NUM_CH) && ((mq[wch].size() < DEPTH) || (pop_ok && rch == wch));
    @(posedge clk);
    #1;
    bus.host_wr = 1'b0; bus.snd_rd = 1'b0; bus.snd_reply_wr = 1'b0; bus.host_reply_rd = 1'b0;
    if (OVF_ON && pop_ok) m_ovf[rch[0]] = 1'b0;
    if (OVF_ON && wr && wch < NUM_CH && !push_ok) m_ovf[wch[0]] = 1'b1;
    if (rd) m_dout = pop_ok ? mq[rch].pop_front() : 8'hFF;
    if (push_ok) mq[wch].push_back(din);
    if (rwr) begin m_reply = rdin; m_valid = 1'b1; end
    else if (rrd) m_valid = 1'b0;
    $display("txn t=%0t wr=%0b/%0d/%02h rd=%0b/%0d rwr=%0b/%02h rrd=%0b -> dout=%02h pend=%b full=%b int_n=%0b nmi_n=%0b vec=%02h",
             $time, wr, wch, din, rd, rch, rwr, rdin, rrd, bus.snd_dout, bus.snd_pending,
             bus.host_full, bus.int_n, bus.nmi_n, bus.irq_vec);
  endtask

  task automatic push(input logic [1:0] ch, input logic [7:0] d);
    cycle(1'b1, ch, d, 1'b0, 2'd0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic pop(input logic [1:0] ch);
    cycle(1'b0, 2'd0, 8'h00, 1'b1, ch, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.host_wr = 1'b0; bus.host_ch = 2'd0; bus.host_din = 8'h00;
    bus.snd_rd = 1'b0; bus.snd_ch = 2'd0; bus.ext_irq_n = 1'b0;
    bus.snd_reply_wr = 1'b0; bus.snd_reply_din = 8'h00; bus.host_reply_rd = 1'b0;
    model_reset();
    #12;
    n_checks++;
    if (bus.int_n !== 1'b0) begin n_fail++; $display("FAIL reset_int_follows_ext: got %b want 0", bus.int_n); end
    bus.ext_irq_n = 1'b1;
    #1;
    n_checks++;
    if ({bus.snd_pending, bus.host_full, bus.snd_dout, bus.int_n, bus.nmi_n, bus.irq_vec,
         bus.host_reply, bus.host_reply_valid, bus.ovf} !==
        {2'b00, 2'b00, 8'hFF, 1'b1, 1'b1, 8'hFF, 8'h00, 1'b0, 2'b00}) begin
      n_fail++;
      $display("FAIL reset_state: pend=%b full=%b dout=%02h int=%b nmi=%b vec=%02h rep=%02h v=%b ovf=%b want 00 00 FF 1 1 FF 00 0 00",
               bus.snd_pending, bus.host_full, bus.snd_dout, bus.int_n, bus.nmi_n, bus.irq_vec,
               bus.host_reply, bus.host_reply_valid, bus.ovf);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_basic_int();
    push(2'd0, 8'h12);
    n_checks++;
    if ({bus.snd_pending, bus.int_n, bus.nmi_n, bus.irq_vec} !== {2'b01, 1'b0, 1'b1, 8'hDF}) begin
      n_fail++;
      $display("FAIL basic_push: pend=%b int=%b nmi=%b vec=%02h want 01 0 1 DF",
               bus.snd_pending, bus.int_n, bus.nmi_n, bus.irq_vec);
    end
    pop(2'd0);
    n_checks++;
    if ({bus.snd_dout, bus.int_n, bus.irq_vec, bus.snd_pending} !== {8'h12, 1'b1, 8'hFF, 2'b00}) begin
      n_fail++;
      $display("FAIL basic_pop: dout=%02h int=%b vec=%02h pend=%b want 12 1 FF 00",
               bus.snd_dout, bus.int_n, bus.irq_vec, bus.snd_pending);
    end
  endtask

  task automatic test_nmi();
    push(2'd1, 8'hA5);
    n_checks++;
    if ({bus.nmi_n, bus.int_n, bus.snd_pending, bus.irq_vec} !== {1'b0, 1'b1, 2'b10, 8'hFF}) begin
      n_fail++;
      $display("FAIL nmi_push: nmi=%b int=%b pend=%b vec=%02h want 0 1 10 FF",
               bus.nmi_n, bus.int_n, bus.snd_pending, bus.irq_vec);
    end
    pop(2'd1);
    n_checks++;
    if ({bus.snd_dout, bus.nmi_n} !== {8'hA5, 1'b1}) begin
      n_fail++;
      $display("FAIL nmi_pop: dout=%02h nmi=%b want A5 1", bus.snd_dout, bus.nmi_n);
    end
  endtask

  task automatic test_full_drop();
    for (int i = 1; i <= 5; i++) begin
      push(2'd0, 8'(i));
      n_checks++;
      if (bus.host_full[0] !== (i >= 4)) begin
        n_fail++;
        $display("FAIL full_flag push%0d: got %b want %b", i, bus.host_full[0], (i >= 4));
      end
    end
    n_checks++;
    if (bus.ovf !== (OVF_ON ? 2'b01 : 2'b00)) begin
      n_fail++;
      $display("FAIL ovf_set: got %b want %b", bus.ovf, (OVF_ON ? 2'b01 : 2'b00));
    end
    for (int i = 1; i <= 5; i++) begin
      pop(2'd0);
      n_checks++;
      if (bus.snd_dout !== ((i <= 4) ? 8'(i) : 8'hFF)) begin
        n_fail++;
        $display("FAIL drop_pop%0d: got %02h want %02h", i, bus.snd_dout, ((i <= 4) ? 8'(i) : 8'hFF));
      end
      if (i == 1) begin
        n_checks++;
        if ({bus.ovf, bus.host_full} !== 4'b0000) begin
          n_fail++;
          $display("FAIL ovf_clear: ovf=%b full=%b want 00 00", bus.ovf, bus.host_full);
        end
      end
    end
  endtask

  task automatic test_push_pop_same();
    for (int i = 0; i < 4; i++) push(2'd0, 8'h10 + 8'(i));
    cycle(1'b1, 2'd0, 8'h77, 1'b1, 2'd0, 1'b0, 8'h00, 1'b0);
    n_checks++;
    if ({bus.snd_dout, bus.host_full[0], bus.ovf} !== {8'h10, 1'b1, 2'b00}) begin
      n_fail++;
      $display("FAIL full_pushpop: dout=%02h full=%b ovf=%b want 10 1 00", bus.snd_dout, bus.host_full[0], bus.ovf);
    end
    for (int i = 0; i < 4; i++) begin
      pop(2'd0);
      n_checks++;
      if (bus.snd_dout !== ((i < 3) ? 8'h11 + 8'(i) : 8'h77)) begin
        n_fail++;
        $display("FAIL drain%0d: got %02h want %02h", i, bus.snd_dout, ((i < 3) ? 8'h11 + 8'(i) : 8'h77));
      end
    end
    cycle(1'b1, 2'd0, 8'h55, 1'b1, 2'd0, 1'b0, 8'h00, 1'b0);
    n_checks++;
    if ({bus.snd_dout, bus.snd_pending} !== {8'hFF, 2'b01}) begin
      n_fail++;
      $display("FAIL empty_pushpop: dout=%02h pend=%b want FF 01", bus.snd_dout, bus.snd_pending);
    end
    pop(2'd0);
    push(2'd3, 8'h99);
    n_checks++;
    if ({bus.snd_dout, bus.snd_pending} !== {8'h55, 2'b00}) begin
      n_fail++;
      $display("FAIL bad_ch_push: dout=%02h pend=%b want 55 00", bus.snd_dout, bus.snd_pending);
    end
    pop(2'd2);
    n_checks++;
    if (bus.snd_dout !== 8'hFF) begin n_fail++; $display("FAIL bad_ch_pop: got %02h want FF", bus.snd_dout); end
  endtask

  task automatic test_ext_reply();
    bus.ext_irq_n = 1'b0;
    push(2'd0, 8'h42);
    n_checks++;
    if ({bus.irq_vec, bus.int_n} !== {8'hCF, 1'b0}) begin
      n_fail++;
      $display("FAIL ext_vec: vec=%02h int=%b want CF 0", bus.irq_vec, bus.int_n);
    end
    cycle(1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 1'b1, 8'h3C, 1'b1);
    n_checks++;
    if ({bus.host_reply, bus.host_reply_valid, bus.irq_vec, bus.int_n} !== {8'h3C, 1'b1, 8'hEF, 1'b0}) begin
      n_fail++;
      $display("FAIL reply_wr_rd: rep=%02h v=%b vec=%02h int=%b want 3C 1 EF 0",
               bus.host_reply, bus.host_reply_valid, bus.irq_vec, bus.int_n);
    end
    cycle(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b1, 8'hC3, 1'b0);
    cycle(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b0, 8'h00, 1'b1);
    n_checks++;
    if ({bus.host_reply, bus.host_reply_valid} !== {8'hC3, 1'b0}) begin
      n_fail++;
      $display("FAIL reply_ack: rep=%02h v=%b want C3 0", bus.host_reply, bus.host_reply_valid);
    end
    bus.ext_irq_n = 1'b1;
  endtask

  task automatic test_random();
    logic [1:0] wch, rch;
    for (int n = 0; n < 400; n++) begin
      wch = 2'($urandom_range(0, 3));
      rch = 2'($urandom_range(0, 3));
      bus.ext_irq_n = ($urandom_range(0, 7) != 0);
      cycle($urandom_range(0, 9) < 6, wch, 8'($urandom), $urandom_range(0, 9) < 4, rch,
            $urandom_range(0, 9) == 0, 8'($urandom), $urandom_range(0, 9) < 2);
      n_checks++;
      if ({bus.snd_pending, bus.host_full, bus.snd_dout, bus.int_n, bus.nmi_n, bus.irq_vec,
           bus.host_reply, bus.host_reply_valid, bus.ovf} !==
          {m_pend(), m_full(), m_dout, ~(~bus.ext_irq_n | m_irq_any()), m_nmi_n(),
           m_vec(bus.ext_irq_n), m_reply, m_valid, m_ovf}) begin
        n_fail++;
        $display("FAIL random%0d: pend=%b full=%b dout=%02h int=%b nmi=%b vec=%02h rep=%02h v=%b ovf=%b want %b %b %02h %b %b %02h %02h %b %b",
                 n, bus.snd_pending, bus.host_full, bus.snd_dout, bus.int_n, bus.nmi_n, bus.irq_vec,
                 bus.host_reply, bus.host_reply_valid, bus.ovf,
                 m_pend(), m_full(), m_dout, ~(~bus.ext_irq_n | m_irq_any()), m_nmi_n(),
                 m_vec(bus.ext_irq_n), m_reply, m_valid, m_ovf);
      end
    end
    bus.ext_irq_n = 1'b1;
  endtask

  task automatic test_reset_midqueue();
    for (int i = 0; i < 4; i++) pop(2'd0);
    for (int i = 0; i < 4; i++) pop(2'd1);
    push(2'd0, 8'h21);
    push(2'd1, 8'h22);
    push(2'd0, 8'h23);
    pop(2'd0);
    push(2'd0, 8'h24);
    n_checks++;
    if ({bus.snd_pending, bus.nmi_n, bus.snd_dout} !== {2'b11, 1'b0, 8'h21}) begin
      n_fail++;
      $display("FAIL pre_reset: pend=%b nmi=%b dout=%02h want 11 0 21", bus.snd_pending, bus.nmi_n, bus.snd_dout);
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if ({bus.snd_pending, bus.nmi_n, bus.snd_dout, bus.int_n} !== {2'b00, 1'b1, 8'hFF, 1'b1}) begin
      n_fail++;
      $display("FAIL mid_reset: pend=%b nmi=%b dout=%02h int=%b want 00 1 FF 1",
               bus.snd_pending, bus.nmi_n, bus.snd_dout, bus.int_n);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    pop(2'd0);
    n_checks++;
    if (bus.snd_dout !== 8'hFF) begin n_fail++; $display("FAIL post_reset_pop: got %02h want FF", bus.snd_dout); end
  endtask

  initial begin
    test_reset();
    test_basic_int();
    test_nmi();
    test_full_drop();
    test_push_pop_same();
    test_ext_reply();
    test_random();
    test_reset_midqueue();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
